// File: rtl/dly_tap_if.sv
// Request/status bundle between a tap-control master and the delay-line tap controller.
// The master drives tap requests and the phase flag; the slave returns the tap state.
interface dly_tap_if #(
  parameter int NUM_TAPS = 32,
  parameter int TAP_W    = 5
);
  logic                sw_tap_load;
  logic [TAP_W-1:0]    sw_tap_val;
  logic                cal_start;
  logic                phase_in;
  logic [NUM_TAPS-1:0] sel_out;
  logic [TAP_W-1:0]    cur_tap;
  logic                busy;
  logic                cal_done;
  logic                cal_err;

  modport master (
    output sw_tap_load, sw_tap_val, cal_start, phase_in,
    input  sel_out, cur_tap, busy, cal_done, cal_err
  );

  modport slave (
    input  sw_tap_load, sw_tap_val, cal_start, phase_in,
    output sel_out, cur_tap, busy, cal_done, cal_err
  );
endinterface

// File: rtl/dly_tap_ctrl.sv
// Delay-line tap controller: walks the del_n_mux chain one tap at a time toward a software
// target or through a calibration sweep, waiting a settle window after every step.
module dly_tap_ctrl #(
  parameter int NUM_TAPS   = 32,
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  dly_tap_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STEP       = 3'd1,
    SETTLE     = 3'd2,
    CAL_SAMPLE = 3'd3,
    DONE       = 3'd4
  } state_e;

  localparam int               CNT_W      = $clog2(SETTLE_CYC + 1);
  localparam logic [TAP_W-1:0] TAP_MAX    = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);

  state_e              state_q, state_d;
  logic [TAP_W-1:0]    cur_tap_q, cur_tap_d;
  logic [TAP_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_TAPS-1:0] sel_q, sel_d;
  logic                cal_mode_q, cal_mode_d;
  logic                first_q, first_d;
  logic                ref_q, ref_d;
  logic                busy_q, busy_d;
  logic                cal_done_q, cal_done_d;
  logic                cal_err_q, cal_err_d;
  logic                ph_s1_q, ph_s1_d;
  logic                ph_s2_q, ph_s2_d;
  logic [TAP_W-1:0]    req_tap_s;

  // Out-of-range requests saturate at the top tap; only needed when the code space exceeds the chain.
  if (NUM_TAPS < (1 << TAP_W)) begin : g_clamp
    assign req_tap_s = (bus.sw_tap_val > TAP_MAX) ? TAP_MAX : bus.sw_tap_val;
  end else begin : g_no_clamp
    assign req_tap_s = bus.sw_tap_val;
  end

  // Next-state, tap stepping, calibration decisions and the registered-output decode.
  always_comb begin
    state_d    = state_q;
    cur_tap_d  = cur_tap_q;
    target_d   = target_q;
    cnt_d      = cnt_q;
    cal_mode_d = cal_mode_q;
    first_d    = first_q;
    ref_d      = ref_q;
    cal_done_d = cal_done_q;
    cal_err_d  = cal_err_q;
    ph_s1_d    = bus.phase_in;
    ph_s2_d    = ph_s1_q;

    case (state_q)
      IDLE: begin
        if (bus.cal_start) begin
          cal_mode_d = 1'b1;
          first_d    = 1'b1;
          target_d   = TAP_W'(0);
          cal_done_d = 1'b0;
          cal_err_d  = 1'b0;
          state_d    = STEP;
        end else if (bus.sw_tap_load) begin
          cal_mode_d = 1'b0;
          first_d    = 1'b0;
          target_d   = req_tap_s;
          cal_done_d = 1'b0;
          cal_err_d  = 1'b0;
          state_d    = STEP;
        end else begin
          state_d = IDLE;
        end
      end
      STEP: begin
        if (cur_tap_q < target_q) begin
          cur_tap_d = cur_tap_q + TAP_W'(1);
          cnt_d     = CNT_W'(0);
          state_d   = SETTLE;
        end else if (cur_tap_q > target_q) begin
          cur_tap_d = cur_tap_q - TAP_W'(1);
          cnt_d     = CNT_W'(0);
          state_d   = SETTLE;
        end else if (cal_mode_q) begin
          state_d = CAL_SAMPLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_END) begin
          if (cur_tap_q != target_q) begin
            state_d = STEP;
          end else if (cal_mode_q) begin
            state_d = CAL_SAMPLE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAL_SAMPLE: begin
        // The first sample is taken at tap 0 and only establishes the reference polarity.
        if (first_q) begin
          first_d  = 1'b0;
          ref_d    = ph_s2_q;
          target_d = cur_tap_q + TAP_W'(1);
          state_d  = STEP;
        end else if (ph_s2_q != ref_q) begin
          cal_done_d = 1'b1;
          state_d    = DONE;
        end else if (cur_tap_q == TAP_MAX) begin
          cal_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          target_d = cur_tap_q + TAP_W'(1);
          state_d  = STEP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == STEP) || (state_d == SETTLE) || (state_d == CAL_SAMPLE);

    sel_d = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      sel_d[i] = (i < int'(cur_tap_d));
    end
  end

  // State and output registers; reset parks the chain at minimum delay immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_tap_q  <= TAP_W'(0);
      target_q   <= TAP_W'(0);
      cnt_q      <= CNT_W'(0);
      sel_q      <= '0;
      cal_mode_q <= 1'b0;
      first_q    <= 1'b0;
      ref_q      <= 1'b0;
      busy_q     <= 1'b0;
      cal_done_q <= 1'b0;
      cal_err_q  <= 1'b0;
      ph_s1_q    <= 1'b0;
      ph_s2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_tap_q  <= cur_tap_d;
      target_q   <= target_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      cal_mode_q <= cal_mode_d;
      first_q    <= first_d;
      ref_q      <= ref_d;
      busy_q     <= busy_d;
      cal_done_q <= cal_done_d;
      cal_err_q  <= cal_err_d;
      ph_s1_q    <= ph_s1_d;
      ph_s2_q    <= ph_s2_d;
    end
  end

  assign bus.sel_out  = sel_q;
  assign bus.cur_tap  = cur_tap_q;
  assign bus.busy     = busy_q;
  assign bus.cal_done = cal_done_q;
  assign bus.cal_err  = cal_err_q;

endmodule
